mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: MEM_LATENCY, default 2, data-memory access latency in cycles; legal range 1..4.
REQ-002 Parameter: DEPTH, default 256, data-memory words of 8 bits, addressed by the full 8-bit ALU result.
REQ-003 The block SHALL have one clock, clk, and a synchronous, active-high reset, rst.
REQ-004 Port: clk  input  1  clock; all state changes on rising edge.
REQ-005 Port: rst  input  1  reset.
REQ-006 Port: in_valid  input  1  EX/MEM register holds a valid instruction.
REQ-007 Port: in_aluResult  input  8  ALU result; memory address for loads and stores.
REQ-008 Port: in_r2  input  8  store data.
REQ-009 Port: in_dest  input  3  destination register index.
REQ-010 Port: in_memRead  input  1  load.
REQ-011 Port: in_memWrite  input  1  store.
REQ-012 Port: in_regWrite  input  1  instruction writes the register file.
REQ-013 Port: stall  output  1  hold the EX/MEM register and all earlier stages.
REQ-014 Port: wb_valid  output  1  wb_* fields are valid this cycle.
REQ-015 Port: wb_data  output  8  load data or pass-through ALU result.
REQ-016 Port: wb_dest  output  3  destination register index.
REQ-017 Port: wb_regWrite  output  1  register-file write enable toward WB.

Function
REQ-018 FSM states SHALL be IDLE and BUSY, and stall SHALL equal (state == BUSY) combinationally.
REQ-019 Accept: the block SHALL latch in_aluResult, in_r2, in_dest, in_memRead, in_memWrite and in_regWrite on an edge where state is IDLE and in_valid is 1.
REQ-020 Non-memory op (memRead=0, memWrite=0): the block SHALL stay IDLE and drive wb_valid=1, wb_data=in_aluResult, wb_dest and wb_regWrite from the inputs in the cycle after acceptance (1-cycle latency).
REQ-021 Memory op: on accept, the block SHALL enter BUSY with a 2-bit down-counter loaded with MEM_LATENCY-1.
REQ-022 In BUSY, each edge SHALL decrement the counter; the edge at which the counter equals 0 SHALL perform the access and return to IDLE.
REQ-023 Load: wb_data SHALL equal mem[latched address], read at the completing edge; wb_valid=1 in the following cycle.
REQ-024 Store: mem[latched address] SHALL receive latched r2 at the completing edge; wb_data SHALL equal the latched address; wb_regWrite SHALL equal the latched in_regWrite.
REQ-025 Memory-op latency: wb_valid SHALL rise MEM_LATENCY+1 edges after the accept edge, and stall SHALL be high for exactly MEM_LATENCY cycles.
REQ-026 memRead and memWrite both 1: the op SHALL be treated as a store.
REQ-027 While BUSY, all in_* ports SHALL be ignored; upstream is required to hold them.
REQ-028 wb_valid SHALL be a single-cycle pulse per instruction, and wb_regWrite SHALL be 0 whenever wb_valid=0.
REQ-029 When wb_valid=0, wb_data and wb_dest SHALL hold their last values.
REQ-030 IDLE with in_valid=0: wb_valid SHALL be 0 in the next cycle and no state change SHALL occur.
REQ-031 Back-to-back ops: an instruction presented in the cycle stall falls SHALL be accepted on that edge, and a load following a store to the same address SHALL return the stored value.

Reset
REQ-032 While rst=1 at an edge: state SHALL become IDLE, counter 0, stall 0, wb_valid 0, wb_regWrite 0, wb_data 0x00, wb_dest 0.
REQ-033 Reset during BUSY SHALL abort the access: no memory write, and no wb_valid pulse for the aborted op.
REQ-034 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-035 Scenario: ALU op aluResult=0x3C, dest=5, regWrite=1 -> next cycle wb_valid=1, wb_data=0x3C, wb_dest=5, wb_regWrite=1; stall never asserted.
REQ-036 Scenario: store r2=0xA5 to 0x10, then load 0x10 to dest=2 (MEM_LATENCY=2) -> stall high for 2 cycles per op; load yields wb_data=0xA5, wb_dest=2, 3 edges after its accept.
REQ-037 Scenario: rst asserted in the second BUSY cycle of a store of 0x77 to 0x20 -> outputs reset, stall=0; a later load of 0x20 does not return 0x77 (returns the prior value).
REQ-038 Scenario: store with memRead=memWrite=1, r2=0x01 to address 0xFF -> treated as a store, mem[0xFF]=0x01, wb_data=0xFF; verifies top-address access.
REQ-039 Scenario: inputs changed while stall=1 -> the result reflects the values latched at accept only.
REQ-040 Scenario: MEM_LATENCY=1 and MEM_LATENCY=4 builds -> stall widths 1 and 4; wb_valid at accept+2 and accept+5.

Source files
------------

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- pipeline MEM stage with a multi-cycle data memory.
//
// Accepts one instruction from the EX/MEM register when idle. ALU-only ops
// are forwarded to WB on the next cycle. Loads and stores hold the pipeline
// (stall) for MEM_LATENCY cycles, then perform the memory access and present
// the result to WB on the following cycle.
//
// Parameters
//   MEM_LATENCY  data-memory access latency in cycles (1..4)
//   DEPTH        number of 8-bit data-memory words (addressed by aluResult)
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   in_valid       EX/MEM register holds a valid instruction
//   in_aluResult   ALU result / memory address
//   in_r2          store data
//   in_dest        destination register index
//   in_memRead     load
//   in_memWrite    store (wins when both memRead and memWrite are set)
//   in_regWrite    instruction writes the register file
//   stall          hold EX/MEM and all earlier stages (high while BUSY)
//   wb_valid       single-cycle pulse: wb_* fields valid
//   wb_data        load data, store address, or pass-through ALU result
//   wb_dest        destination register index
//   wb_regWrite    register-file write enable toward WB (0 when !wb_valid)
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int MEM_LATENCY = 2,
  parameter int DEPTH       = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_aluResult,
  input  logic [7:0] in_r2,
  input  logic [2:0] in_dest,
  input  logic       in_memRead,
  input  logic       in_memWrite,
  input  logic       in_regWrite,
  output logic       stall,
  output logic       wb_valid,
  output logic [7:0] wb_data,
  output logic [2:0] wb_dest,
  output logic       wb_regWrite
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Counter is loaded with MEM_LATENCY-1 so BUSY lasts exactly MEM_LATENCY
  // cycles: the access happens on the edge that finds the counter at zero.
  localparam logic [1:0] CNT_INIT = 2'(MEM_LATENCY - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0] state;
  logic [1:0] cnt;

  // Instruction captured at accept; in_* are ignored while BUSY.
  logic [7:0] lat_addr;
  logic [7:0] lat_r2;
  logic [2:0] lat_dest;
  logic       lat_store;
  logic       lat_regwrite;

  logic [7:0] mem [DEPTH];

  logic          accept;
  logic          is_mem_op;
  logic          done;
  logic [AW-1:0] mem_idx;

  assign stall     = (state == BUSY);
  assign accept    = (state == IDLE) && in_valid;
  assign is_mem_op = in_memRead || in_memWrite;
  assign done      = (state == BUSY) && (cnt == 2'd0);
  assign mem_idx   = lat_addr[AW-1:0];

  // Control, capture and WB output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      lat_addr     <= '0;
      lat_r2       <= '0;
      lat_dest     <= '0;
      lat_store    <= 1'b0;
      lat_regwrite <= 1'b0;
      wb_valid     <= 1'b0;
      wb_regWrite  <= 1'b0;
      wb_data      <= '0;
      wb_dest      <= '0;
    end else begin
      // wb_valid / wb_regWrite are pulses; data and dest hold otherwise.
      wb_valid    <= 1'b0;
      wb_regWrite <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            lat_addr     <= in_aluResult;
            lat_r2       <= in_r2;
            lat_dest     <= in_dest;
            // Only memory ops reach BUSY, so "not a store" there means load.
            lat_store    <= in_memWrite;
            lat_regwrite <= in_regWrite;
            if (is_mem_op) begin
              state <= BUSY;
              cnt   <= CNT_INIT;
            end else begin
              wb_valid    <= 1'b1;
              wb_data     <= in_aluResult;
              wb_dest     <= in_dest;
              wb_regWrite <= in_regWrite;
            end
          end
        end
        BUSY: begin
          if (done) begin
            state       <= IDLE;
            wb_valid    <= 1'b1;
            wb_dest     <= lat_dest;
            wb_regWrite <= lat_regwrite;
            wb_data     <= lat_store ? lat_addr : mem[mem_idx];
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Data memory: never cleared; a reset on the completing edge aborts the write.
  always_ff @(posedge clk) begin
    if (!rst && done && lat_store) begin
      mem[mem_idx] <= lat_r2;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage -- self-checking bench for mem_stage.
// Three instances (MEM_LATENCY 1, 2, 4) are exercised one after another with
// directed scenarios and randomized instruction streams. A transaction-level
// model (per-instance memory image, expected result and latency per op)
// supplies all expected values.
// -----------------------------------------------------------------------------
module tb_mem_stage;

  localparam int NI = 3;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 4;
  endfunction

  logic       clk = 1'b0;
  logic       rst          [NI];
  logic       in_valid     [NI];
  logic [7:0] in_aluResult [NI];
  logic [7:0] in_r2        [NI];
  logic [2:0] in_dest      [NI];
  logic       in_memRead   [NI];
  logic       in_memWrite  [NI];
  logic       in_regWrite  [NI];
  logic       stall        [NI];
  logic       wb_valid     [NI];
  logic [7:0] wb_data      [NI];
  logic [2:0] wb_dest      [NI];
  logic       wb_regWrite  [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_stage #(.MEM_LATENCY(lat_of(g)), .DEPTH(256)) u_dut (
      .clk         (clk),
      .rst         (rst[g]),
      .in_valid    (in_valid[g]),
      .in_aluResult(in_aluResult[g]),
      .in_r2       (in_r2[g]),
      .in_dest     (in_dest[g]),
      .in_memRead  (in_memRead[g]),
      .in_memWrite (in_memWrite[g]),
      .in_regWrite (in_regWrite[g]),
      .stall       (stall[g]),
      .wb_valid    (wb_valid[g]),
      .wb_data     (wb_data[g]),
      .wb_dest     (wb_dest[g]),
      .wb_regWrite (wb_regWrite[g])
    );
  end

  // Reference state
  logic [7:0] ref_mem   [NI][256];
  logic [7:0] last_data [NI];
  logic [2:0] last_dest [NI];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input int k);
    check_eq("rst_stall", 32'(stall[k]), 32'd0);
    check_eq("rst_wb_valid", 32'(wb_valid[k]), 32'd0);
    check_eq("rst_wb_regWrite", 32'(wb_regWrite[k]), 32'd0);
    check_eq("rst_wb_data", 32'(wb_data[k]), 32'h00);
    check_eq("rst_wb_dest", 32'(wb_dest[k]), 32'd0);
  endtask

  task automatic drive(input int k, input logic v, input logic rd, input logic wr,
                       input logic rw, input logic [7:0] a, input logic [7:0] d,
                       input logic [2:0] dst);
    in_valid[k]     = v;
    in_memRead[k]   = rd;
    in_memWrite[k]  = wr;
    in_regWrite[k]  = rw;
    in_aluResult[k] = a;
    in_r2[k]        = d;
    in_dest[k]      = dst;
  endtask

  task automatic idle_cycle(input int k);
    @(negedge clk);
    in_valid[k] = 1'b0;
    @(posedge clk); #1;
    check_eq("idle_stall", 32'(stall[k]), 32'd0);
    check_eq("idle_wb_valid", 32'(wb_valid[k]), 32'd0);
    check_eq("idle_wb_regWrite", 32'(wb_regWrite[k]), 32'd0);
    check_eq("idle_hold_data", 32'(wb_data[k]), 32'(last_data[k]));
    check_eq("idle_hold_dest", 32'(wb_dest[k]), 32'(last_dest[k]));
  endtask

  // Issue one instruction and follow it to its WB pulse.
  // ALU op: result one edge after accept. Memory op: stall for L cycles,
  // result after the (L+1)-th edge counting the accept edge.
  task automatic do_op(input int k, input logic rd, input logic wr, input logic rw,
                       input logic [7:0] a, input logic [7:0] d, input logic [2:0] dst,
                       input bit perturb);
    int L;
    logic [7:0] exp_data;
    L = lat_of(k);
    if (!(rd || wr))  exp_data = a;
    else if (wr)      exp_data = a;
    else              exp_data = ref_mem[k][a];
    @(negedge clk);
    drive(k, 1'b1, rd, wr, rw, a, d, dst);
    @(posedge clk); #1;
    if (!(rd || wr)) begin
      check_eq("alu_stall", 32'(stall[k]), 32'd0);
      check_eq("alu_wb_valid", 32'(wb_valid[k]), 32'd1);
      check_eq("alu_wb_data", 32'(wb_data[k]), 32'(exp_data));
      check_eq("alu_wb_dest", 32'(wb_dest[k]), 32'(dst));
      check_eq("alu_wb_regWrite", 32'(wb_regWrite[k]), 32'(rw));
    end else begin
      for (int i = 0; i < L; i++) begin
        if (i > 0) begin
          @(posedge clk); #1;
        end
        check_eq("busy_stall", 32'(stall[k]), 32'd1);
        check_eq("busy_wb_valid", 32'(wb_valid[k]), 32'd0);
        check_eq("busy_wb_regWrite", 32'(wb_regWrite[k]), 32'd0);
        if (perturb) begin
          @(negedge clk);
          drive(k, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                8'($urandom), 8'($urandom), 3'($urandom));
        end
      end
      @(posedge clk); #1;
      check_eq("mem_stall_fall", 32'(stall[k]), 32'd0);
      check_eq("mem_wb_valid", 32'(wb_valid[k]), 32'd1);
      check_eq(wr ? "st_wb_data" : "ld_wb_data", 32'(wb_data[k]), 32'(exp_data));
      check_eq("mem_wb_dest", 32'(wb_dest[k]), 32'(dst));
      check_eq("mem_wb_regWrite", 32'(wb_regWrite[k]), 32'(rw));
      if (wr) ref_mem[k][a] = d;
    end
    last_data[k] = exp_data;
    last_dest[k] = dst;
  endtask

  // Store 0x77 to 0x20, reset during its second BUSY cycle (first if L=1).
  task automatic abort_store(input int k);
    int nb;
    nb = (lat_of(k) >= 2) ? 2 : 1;
    @(negedge clk);
    drive(k, 1'b1, 1'b0, 1'b1, 1'b0, 8'h20, 8'h77, 3'd1);
    @(posedge clk); #1;
    check_eq("abort_busy", 32'(stall[k]), 32'd1);
    for (int i = 1; i < nb; i++) @(posedge clk);
    @(negedge clk);
    rst[k] = 1'b1;
    in_valid[k] = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs(k);
    @(negedge clk);
    rst[k] = 1'b0;
    last_data[k] = 8'h00;
    last_dest[k] = 3'd0;
    @(posedge clk); #1;
    check_eq("abort_no_pulse", 32'(wb_valid[k]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1;
      drive(k, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0);
      last_data[k] = 8'h00;
      last_dest[k] = 3'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) check_reset_outputs(k);
    @(negedge clk);
    for (int k = 0; k < NI; k++) rst[k] = 1'b0;

    for (int k = 0; k < NI; k++) begin
      idle_cycle(k);
      // ALU pass-through
      do_op(k, 1'b0, 1'b0, 1'b1, 8'h3C, 8'h00, 3'd5, 1'b0);
      do_op(k, 1'b0, 1'b0, 1'b0, 8'hC3, 8'h11, 3'd6, 1'b0);
      idle_cycle(k);
      // Known memory image for loads
      do_op(k, 1'b0, 1'b1, 1'b0, 8'h20, 8'h33, 3'd0, 1'b0);
      for (int a = 8'h10; a < 8'h18; a++)
        do_op(k, 1'b0, 1'b1, 1'($urandom), 8'(a), 8'($urandom), 3'($urandom), 1'b0);
      // Store then load same address, back to back
      do_op(k, 1'b0, 1'b1, 1'b0, 8'h10, 8'hA5, 3'd3, 1'b0);
      do_op(k, 1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 3'd2, 1'b0);
      // Both read and write set: store to the top address
      do_op(k, 1'b1, 1'b1, 1'b0, 8'hFF, 8'h01, 3'd4, 1'b0);
      do_op(k, 1'b1, 1'b0, 1'b1, 8'hFF, 8'h00, 3'd7, 1'b0);
      // Inputs wiggled during BUSY
      do_op(k, 1'b0, 1'b1, 1'b1, 8'h12, 8'h5A, 3'd1, 1'b1);
      do_op(k, 1'b1, 1'b0, 1'b1, 8'h12, 8'h00, 3'd6, 1'b1);
      // Aborted store leaves the previous value
      abort_store(k);
      do_op(k, 1'b1, 1'b0, 1'b1, 8'h20, 8'h00, 3'd2, 1'b0);
      idle_cycle(k);
      // Random stream
      for (int n = 0; n < 40; n++) begin
        int sel;
        sel = int'($urandom_range(0, 3));
        case (sel)
          0: do_op(k, 1'b0, 1'b0, 1'($urandom), 8'($urandom), 8'($urandom),
                   3'($urandom), 1'b0);
          1: do_op(k, 1'($urandom), 1'b1, 1'($urandom),
                   8'h10 + 8'($urandom_range(0, 7)), 8'($urandom), 3'($urandom),
                   1'($urandom));
          2: do_op(k, 1'b1, 1'b0, 1'($urandom),
                   8'h10 + 8'($urandom_range(0, 7)), 8'($urandom), 3'($urandom),
                   1'($urandom));
          default: idle_cycle(k);
        endcase
      end
      idle_cycle(k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
